// File: rtl/relu_pool_writer.sv
// relu_pool_writer
//   Consumes signed ReLU samples, clamps negatives to zero, max-pools
//   consecutive pairs within a row (an odd trailing sample passes alone),
//   quantizes by an arithmetic right shift with saturation, and queues the
//   results in a first-word-fall-through FIFO.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_data/in_last    sample stream in; in_ready = FIFO not full
//   out_valid/out_data/out_last pooled stream out; out_ready pops the head
//   frame_done                  registered pulse the cycle after a last pop
module relu_pool_writer #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 8,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_HELD  = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] held_q, held_d;
  logic [OUT_W-1:0] mem_data_q [DEPTH];
  logic             mem_last_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             frame_done_q;

  logic             accept, pop, push, push_last;
  logic [WIDTH-1:0] clamped, pooled, push_val, shifted;
  logic [OUT_W-1:0] push_q8;

  assign in_ready  = (count_q != (AW+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = mem_data_q[rd_ptr_q];
  assign out_last  = mem_last_q[rd_ptr_q];
  assign frame_done = frame_done_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Both operands of the max are already non-negative, so an unsigned
  // compare is correct.
  assign clamped = in_data[WIDTH-1] ? '0 : in_data;
  assign pooled  = (held_q > clamped) ? held_q : clamped;

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    push      = 1'b0;
    push_val  = clamped;
    push_last = in_last;
    if (accept) begin
      if (state_q == ST_EMPTY) begin
        if (in_last) begin
          push = 1'b1;
        end else begin
          held_d  = clamped;
          state_d = ST_HELD;
        end
      end else begin
        push     = 1'b1;
        push_val = pooled;
        state_d  = ST_EMPTY;
      end
    end
  end

  // push_val is non-negative, so a logical shift equals the arithmetic one;
  // any set bit above OUT_W means the value exceeds the output range.
  assign shifted = push_val >> SHIFT;
  assign push_q8 = (|shifted[WIDTH-1:OUT_W]) ? '1 : shifted[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      held_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      frame_done_q <= pop & mem_last_q[rd_ptr_q];
      if (push) begin
        mem_data_q[wr_ptr_q] <= push_q8;
        mem_last_q[wr_ptr_q] <= push_last;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_relu_pool_writer.sv
module tb_relu_pool_writer;
  localparam int WIDTH = 32;
  localparam int OUT_W = 8;
  localparam int SHIFT = 8;
  localparam int DEPTH = 4;
  localparam int BUDGET = 3000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_last;
  logic                    in_ready;
  logic                    out_valid;
  logic [OUT_W-1:0]        out_data;
  logic                    out_last;
  logic                    out_ready;
  logic                    frame_done;

  relu_pool_writer #(.WIDTH(WIDTH), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  typedef struct packed { logic [31:0] d; logic l; } smp_t;

  exp_t    exp_q[$];
  smp_t    stim[$];
  int      pass_cnt = 0;
  int      total_cnt = 0;
  logic    m_held_v = 1'b0;
  longint  m_held = 0;
  logic    m_fd = 1'b0;

  function automatic logic [7:0] quant(input longint x);
    longint y;
    if (x < 0) x = 0;
    y = x >>> SHIFT;
    if (y > 255) y = 255;
    return 8'(y);
  endfunction

  function automatic smp_t mk(input int d, input logic l);
    smp_t s;
    s.d = d;
    s.l = l;
    return s;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_held_v = 1'b0;
    m_held   = 0;
    m_fd     = 1'b0;
  endfunction

  // Drives one cycle (called at a falling edge), samples the DUT, forms the
  // model's expectation for that sample and advances the model over the edge.
  task automatic drive_cycle(input logic v, input smp_t s, input logic r,
                             output logic [11:0] got, output logic [11:0] exp,
                             output logic acc);
    int     n;
    exp_t   h;
    longint c, mx;
    in_valid  = v;
    in_data   = s.d;
    in_last   = s.l;
    out_ready = r;
    #1;
    n = exp_q.size();
    h = (n != 0) ? exp_q[0] : '0;
    got = {in_ready, out_valid, out_valid ? {out_data, out_last} : 9'h0, frame_done};
    exp = {n < DEPTH, n != 0, (n != 0) ? {h.d, h.l} : 9'h0, m_fd};
    acc = v && (n < DEPTH);
    m_fd = (n != 0) && r && h.l;
    if ((n != 0) && r) void'(exp_q.pop_front());
    if (acc) begin
      c = ($signed(s.d) < 0) ? 0 : longint'($signed(s.d));
      if (!m_held_v && !s.l) begin
        m_held_v = 1'b1;
        m_held   = c;
      end else begin
        mx = (m_held_v && m_held > c) ? m_held : c;
        exp_q.push_back({quant(mx), s.l});
        m_held_v = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h700; in_last = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    got = {in_ready, out_valid, out_data, out_last, frame_done};
    total_cnt++;
    if (got !== 12'b1_0_00000000_0_0) $display("FAIL reset_state got=%h exp=%h", got, 12'h800);
    else pass_cnt++;
    in_valid = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  // REQ: 0x300, 0x500(last) -> 5/last, frame_done the following cycle.
  task automatic test_pair_frame_done();
    logic [11:0] got, exp; logic acc;
    stim.push_back(mk(32'h300, 1'b0));
    stim.push_back(mk(32'h500, 1'b1));
    for (int cyc = 0; cyc < BUDGET && (stim.size() != 0 || exp_q.size() != 0 || m_fd); cyc++) begin
      drive_cycle(stim.size() != 0, (stim.size() != 0) ? stim[0] : '0, 1'b1, got, exp, acc);
      if (acc) void'(stim.pop_front());
      total_cnt++;
      if (got !== exp) $display("FAIL pair cyc=%0d got=%h exp=%h", cyc, got, exp);
      else pass_cnt++;
    end
    total_cnt++;
    if (stim.size() != 0 || exp_q.size() != 0) $display("FAIL pair_timeout left=%0d exp=0", exp_q.size());
    else pass_cnt++;
  endtask

  // Saturation pairs, a negative clamp, and an odd-length row.
  task automatic test_saturation_odd_row();
    logic [11:0] got, exp; logic acc;
    stim.push_back(mk(32'h10000, 1'b0)); stim.push_back(mk(32'h0, 1'b0));
    stim.push_back(mk(-32'sh100, 1'b0)); stim.push_back(mk(32'h2FF, 1'b0));
    stim.push_back(mk(32'h100, 1'b0));   stim.push_back(mk(32'h200, 1'b0));
    stim.push_back(mk(32'h700, 1'b1));
    stim.push_back(mk(-32'sh7FFF, 1'b1));
    for (int cyc = 0; cyc < BUDGET && (stim.size() != 0 || exp_q.size() != 0 || m_fd); cyc++) begin
      drive_cycle(stim.size() != 0, (stim.size() != 0) ? stim[0] : '0, 1'b1, got, exp, acc);
      if (acc) void'(stim.pop_front());
      total_cnt++;
      if (got !== exp) $display("FAIL sat_odd cyc=%0d got=%h exp=%h", cyc, got, exp);
      else pass_cnt++;
    end
    total_cnt++;
    if (stim.size() != 0 || exp_q.size() != 0 || m_held_v) $display("FAIL sat_odd_end left=%0d exp=0", exp_q.size());
    else pass_cnt++;
  endtask

  // Ten samples against a stalled sink fill the FIFO; then the sink drains it.
  task automatic test_backpressure();
    logic [11:0] got, exp; logic acc;
    for (int i = 0; i < 10; i++) stim.push_back(mk(32'h80 + i * 32'h100, i == 9));
    for (int cyc = 0; cyc < BUDGET && (stim.size() != 0 || exp_q.size() != 0 || m_fd); cyc++) begin
      drive_cycle(stim.size() != 0, (stim.size() != 0) ? stim[0] : '0, cyc >= 14, got, exp, acc);
      if (acc) void'(stim.pop_front());
      total_cnt++;
      if (got !== exp) $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, got, exp);
      else pass_cnt++;
    end
    total_cnt++;
    if (stim.size() != 0 || exp_q.size() != 0) $display("FAIL backpressure_timeout left=%0d exp=0", exp_q.size());
    else pass_cnt++;
  endtask

  // Reset with a half pair held and two FIFO entries queued.
  task automatic test_reset_mid();
    logic [11:0] got, exp; logic acc;
    logic [11:0] snap;
    stim.push_back(mk(32'h100, 1'b0)); stim.push_back(mk(32'h200, 1'b0));
    stim.push_back(mk(32'h300, 1'b0)); stim.push_back(mk(32'h400, 1'b1));
    stim.push_back(mk(32'h500, 1'b0));
    for (int cyc = 0; cyc < BUDGET && stim.size() != 0; cyc++) begin
      drive_cycle(1'b1, stim[0], 1'b0, got, exp, acc);
      if (acc) void'(stim.pop_front());
      total_cnt++;
      if (got !== exp) $display("FAIL rst_mid_fill cyc=%0d got=%h exp=%h", cyc, got, exp);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    snap = {in_ready, out_valid, out_data, out_last, frame_done};
    total_cnt++;
    if (snap !== 12'h800) $display("FAIL rst_mid_async got=%h exp=%h", snap, 12'h800);
    else pass_cnt++;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stim.push_back(mk(32'h400, 1'b0));
    stim.push_back(mk(32'h100, 1'b1));
    for (int cyc = 0; cyc < BUDGET && (stim.size() != 0 || exp_q.size() != 0 || m_fd); cyc++) begin
      drive_cycle(stim.size() != 0, (stim.size() != 0) ? stim[0] : '0, 1'b1, got, exp, acc);
      if (acc) void'(stim.pop_front());
      total_cnt++;
      if (got !== exp) $display("FAIL rst_mid_after cyc=%0d got=%h exp=%h", cyc, got, exp);
      else pass_cnt++;
    end
  endtask

  // Random samples, row ends and sink stalls, exercising pointer wrap and
  // simultaneous push/pop at every fill level.
  task automatic test_back_to_back();
    logic [11:0] got, exp; logic acc;
    int tmp;
    for (int i = 0; i < 150; i++) begin
      tmp = int'($urandom_range(0, 90000));
      stim.push_back(mk(($urandom_range(0, 3) == 0) ? -tmp : tmp,
                        ($urandom_range(0, 3) == 0) || (i == 149)));
    end
    for (int cyc = 0; cyc < BUDGET && (stim.size() != 0 || exp_q.size() != 0 || m_fd); cyc++) begin
      drive_cycle((stim.size() != 0) && ($urandom_range(0, 4) != 0),
                  (stim.size() != 0) ? stim[0] : '0, $urandom_range(0, 2) != 0, got, exp, acc);
      if (acc) void'(stim.pop_front());
      total_cnt++;
      if (got !== exp) $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, got, exp);
      else pass_cnt++;
    end
    total_cnt++;
    if (stim.size() != 0 || exp_q.size() != 0) $display("FAIL b2b_timeout left=%0d exp=0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_pair_frame_done();
    test_saturation_odd_row();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
